// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Purpose:
//   Multi-cycle control FSM for the accumulator RISC CPU. Each instruction is
//   sequenced through FETCH / DECODE / (EXEC | MEM) / WB, with a req/ack memory
//   handshake, a zero-flag-driven skip (SKZ), a sticky halt and a single-step
//   debug mode. The FSM state and every control output are registered.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   opcode     in   [OP_W]    instruction-register opcode field
//   acc_zero   in   accumulator == 0
//   mem_ack    in   memory completion, sampled on the clock edge
//   step_en    in   single-step mode enable
//   step_go    in   releases one instruction while in IDLE with step_en=1
//   mem_req    out  memory request, held until ack
//   mem_we     out  memory write (STO data phase)
//   ir_load    out  load instruction register
//   pc_inc     out  PC += 1
//   pc_load    out  PC <= operand address (JMP)
//   acc_load   out  accumulator write enable
//   alu_to_acc out  accumulator source: 1 = ALU, 0 = memory data
//   alu_op     out  [ALUOP_W] 01 ADD, 10 AND, 11 XOR, 00 pass
//   halted     out  controller is in HALT
//   illegal    out  sticky: an illegal opcode was decoded
//   state_o    out  [3] current FSM state (debug visibility)
//
// Memory handshake:
//   mem_req is high for every cycle of FETCH and MEM. A transfer completes on
//   the first rising edge where mem_req=1 and mem_ack=1, including the very
//   first cycle of the request (zero-wait memory). mem_ack is ignored while
//   mem_req=0, and reset drops mem_req at once without waiting for ack.
// -----------------------------------------------------------------------------
module multicycle_controller #(
   parameter int OP_W    = 3,
   parameter int ALUOP_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    opcode,
   input  logic               acc_zero,
   input  logic               mem_ack,
   input  logic               step_en,
   input  logic               step_go,
   output logic               mem_req,
   output logic               mem_we,
   output logic               ir_load,
   output logic               pc_inc,
   output logic               pc_load,
   output logic               acc_load,
   output logic               alu_to_acc,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               halted,
   output logic               illegal,
   output logic [2:0]         state_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   logic [2:0]         state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic               illegal_q, illegal_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic               ir_load_q, ir_load_d;
   logic               pc_inc_q, pc_inc_d;
   logic               pc_load_q, pc_load_d;
   logic               acc_load_q, acc_load_d;
   logic               alu_to_acc_q, alu_to_acc_d;
   logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
   logic               halted_q, halted_d;
   logic               upper_nz;

   // Only bits [2:0] are decoded; any set bit above them makes the opcode
   // illegal. With the default OP_W=3 there are no upper bits to inspect.
   generate
      if (OP_W > 3) begin : g_wide_op
         assign upper_nz = |opcode[OP_W-1:3];
      end else begin : g_narrow_op
         assign upper_nz = 1'b0;
      end
   endgenerate

   // Next-state logic. The opcode is captured on the edge leaving DECODE so
   // later phases do not depend on the IR field staying stable.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE: begin
            // step_go only matters here; outside IDLE it is never looked at.
            if (!step_en || step_go) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (mem_ack) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            op_d = opcode[2:0];
            if (upper_nz) begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               case (opcode[2:0])
                  OP_HLT:         state_d = S_HALT;
                  OP_SKZ, OP_JMP: state_d = S_EXEC;
                  default:        state_d = S_MEM;
               endcase
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               state_d = (op_q == OP_STO) ? S_IDLE : S_WB;
            end
         end
         S_EXEC:  state_d = S_IDLE;
         S_WB:    state_d = S_IDLE;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered: each one is computed from the state being
   // entered, so it is valid for the whole cycle spent in that state.
   always_comb begin
      mem_req_d    = (state_d == S_FETCH) || (state_d == S_MEM);
      mem_we_d     = (state_d == S_MEM) && (op_d == OP_STO);
      ir_load_d    = (state_d == S_DECODE);
      // EXEC is only entered from DECODE, so acc_zero is the value seen on
      // the decode edge.
      pc_inc_d     = (state_d == S_DECODE) ||
                     ((state_d == S_EXEC) && (op_d == OP_SKZ) && acc_zero);
      pc_load_d    = (state_d == S_EXEC) && (op_d == OP_JMP);
      acc_load_d   = (state_d == S_WB);
      alu_to_acc_d = (state_d == S_WB) && (op_d != OP_LDA);
      halted_d     = (state_d == S_HALT);
      alu_op_d     = '0;
      if (state_d == S_WB) begin
         case (op_d)
            OP_ADD:  alu_op_d = ALUOP_W'(2'b01);
            OP_AND:  alu_op_d = ALUOP_W'(2'b10);
            OP_XOR:  alu_op_d = ALUOP_W'(2'b11);
            default: alu_op_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         op_q         <= OP_HLT;
         illegal_q    <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         ir_load_q    <= 1'b0;
         pc_inc_q     <= 1'b0;
         pc_load_q    <= 1'b0;
         acc_load_q   <= 1'b0;
         alu_to_acc_q <= 1'b0;
         alu_op_q     <= '0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         illegal_q    <= illegal_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         ir_load_q    <= ir_load_d;
         pc_inc_q     <= pc_inc_d;
         pc_load_q    <= pc_load_d;
         acc_load_q   <= acc_load_d;
         alu_to_acc_q <= alu_to_acc_d;
         alu_op_q     <= alu_op_d;
         halted_q     <= halted_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign ir_load    = ir_load_q;
   assign pc_inc     = pc_inc_q;
   assign pc_load    = pc_load_q;
   assign acc_load   = acc_load_q;
   assign alu_to_acc = alu_to_acc_q;
   assign alu_op     = alu_op_q;
   assign halted     = halted_q;
   assign illegal    = illegal_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller (built with OP_W=4 so that
// opcodes with a set upper bit can be presented). Every cycle has one
// expected output vector plus the inputs to apply during that cycle; the
// expected vectors come from the instruction timing of the controller.
// Outputs are sampled on the falling edge, inputs change right after.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   localparam int OP_W    = 4;
   localparam int ALUOP_W = 2;
   localparam int VW      = 14;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   logic               clk;
   logic               rst_n;
   logic [OP_W-1:0]    opcode;
   logic               acc_zero;
   logic               mem_ack;
   logic               step_en;
   logic               step_go;
   logic               mem_req;
   logic               mem_we;
   logic               ir_load;
   logic               pc_inc;
   logic               pc_load;
   logic               acc_load;
   logic               alu_to_acc;
   logic [ALUOP_W-1:0] alu_op;
   logic               halted;
   logic               illegal;
   logic [2:0]         state_o;

   logic [VW-1:0]      obs;
   logic [VW-1:0]      exp_q[$];
   logic               ack_q[$];
   logic [OP_W-1:0]    op_q[$];
   logic               go_q[$];
   logic               exp_ill;
   int                 n_vec;
   int                 n_err;

   multicycle_controller #(
      .OP_W    (OP_W),
      .ALUOP_W (ALUOP_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .acc_zero   (acc_zero),
      .mem_ack    (mem_ack),
      .step_en    (step_en),
      .step_go    (step_go),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .ir_load    (ir_load),
      .pc_inc     (pc_inc),
      .pc_load    (pc_load),
      .acc_load   (acc_load),
      .alu_to_acc (alu_to_acc),
      .alu_op     (alu_op),
      .halted     (halted),
      .illegal    (illegal),
      .state_o    (state_o)
   );

   assign obs = {state_o, mem_req, mem_we, ir_load, pc_inc, pc_load,
                 acc_load, alu_to_acc, alu_op, halted, illegal};

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- expected-vector construction ----------------
   function automatic logic [VW-1:0] vec(input logic [2:0] st, input logic req,
                                         input logic we, input logic irl,
                                         input logic pci, input logic pcl,
                                         input logic accl, input logic a2a,
                                         input logic [1:0] aop);
      return {st, req, we, irl, pci, pcl, accl, a2a, aop, (st == S_HALT), exp_ill};
   endfunction

   function automatic logic [OP_W-1:0] scr();
      return OP_W'($urandom_range(0, 7));
   endfunction

   task automatic push(input logic [VW-1:0] v, input logic ack,
                       input logic [OP_W-1:0] op, input logic go);
      exp_q.push_back(v);
      ack_q.push_back(ack);
      op_q.push_back(op);
      go_q.push_back(go);
   endtask

   // One instruction starting in IDLE: f FETCH wait cycles, m MEM wait cycles
   // (ack on the last of each). After DECODE the opcode input is scrambled.
   task automatic expect_instr(input logic [OP_W-1:0] op, input int f, input int m,
                               input logic az, input logic go_idle, input logic go_busy);
      logic [2:0] o;
      logic [1:0] aop;
      o = op[2:0];
      push(vec(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, op, go_idle);
      for (int j = 1; j <= f; j++)
         push(vec(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), (j == f), op, go_busy);
      push(vec(S_DECODE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, op, go_busy);
      if (op[OP_W-1:3] != '0) begin
         exp_ill = 1'b1;
         return;
      end
      case (o)
         3'd0: ;
         3'd1: push(vec(S_EXEC, 1'b0, 1'b0, 1'b0, az, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, scr(), go_busy);
         3'd7: push(vec(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00), 1'b0, scr(), go_busy);
         default: begin
            for (int j = 1; j <= m; j++)
               push(vec(S_MEM, 1'b1, (o == 3'd6), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00),
                    (j == m), scr(), go_busy);
            if (o != 3'd6) begin
               case (o)
                  3'd2:    aop = 2'b01;
                  3'd3:    aop = 2'b10;
                  3'd4:    aop = 2'b11;
                  default: aop = 2'b00;
               endcase
               push(vec(S_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (o != 3'd5), aop),
                    1'b0, scr(), go_busy);
            end
         end
      endcase
   endtask

   task automatic push_halt(input int n);
      for (int j = 0; j < n; j++)
         push(vec(S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00),
              1'($urandom_range(0, 1)), scr(), 1'($urandom_range(0, 1)));
   endtask

   // ---------------- driver ----------------
   task automatic drive_next();
      mem_ack = ack_q.pop_front();
      opcode  = op_q.pop_front();
      step_go = go_q.pop_front();
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [VW-1:0] e;
      int cyc;
      rst_n = 1'b0; step_en = 1'b0; step_go = 1'b0; mem_ack = 1'b0;
      opcode = '0; acc_zero = 1'b0; exp_ill = 1'b0;
      repeat (2) @(negedge clk);
      e = vec(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_values got=%h exp=%h", obs, e);
      end
      rst_n = 1'b1;
      // ADD that gets stuck in MEM waiting for ack
      push(vec(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 4'd2, 1'b0);
      push(vec(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b1, 4'd2, 1'b0);
      push(vec(S_DECODE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 4'd2, 1'b0);
      push(vec(S_MEM, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 4'd2, 1'b0);
      push(vec(S_MEM, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 4'd2, 1'b0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL reset_pre_mem cyc=%0d got=%h exp=%h", cyc, obs, e);
         end
         cyc++;
         drive_next();
      end
      e = vec(S_MEM, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_mem_wait got=%h exp=%h", obs, e);
      end
      #2 rst_n = 1'b0;
      #1;
      e = vec(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_async_mid_mem got=%h exp=%h", obs, e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // first vector is the IDLE cycle right after release, then FETCH
      expect_instr(4'd5, 1, 1, 1'b0, 1'b0, 1'b0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, obs, e);
         end
         cyc++;
         drive_next();
      end
   endtask

   task automatic test_alu_zero_wait();
      logic [VW-1:0] e;
      int cyc;
      expect_instr(4'd2, 1, 1, 1'b0, 1'b0, 1'b0);
      expect_instr(4'd2, 1, 1, 1'b0, 1'b0, 1'b0);
      expect_instr(4'd3, 1, 1, 1'b0, 1'b0, 1'b0);
      expect_instr(4'd4, 1, 1, 1'b0, 1'b0, 1'b0);
      expect_instr(4'd5, 1, 1, 1'b0, 1'b0, 1'b0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL alu_zero_wait cyc=%0d got=%h exp=%h", cyc, obs, e);
         end
         cyc++;
         drive_next();
      end
   endtask

   task automatic test_sto_wait();
      logic [VW-1:0] e;
      int cyc;
      expect_instr(4'd6, 1, 3, 1'b0, 1'b0, 1'b0);
      expect_instr(4'd6, 2, 1, 1'b0, 1'b0, 1'b0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL sto_wait cyc=%0d got=%h exp=%h", cyc, obs, e);
         end
         cyc++;
         drive_next();
      end
   endtask

   task automatic test_skz();
      logic [VW-1:0] e;
      int cnt;
      for (int k = 0; k < 2; k++) begin
         acc_zero = (k == 0);
         expect_instr(4'd1, 1 + k, 1, acc_zero, 1'b0, 1'b0);
         cnt = 0;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (pc_inc === 1'b1) cnt++;
            n_vec++;
            if (obs !== e) begin
               n_err++;
               $display("FAIL skz_az%0d got=%h exp=%h", acc_zero, obs, e);
            end
            drive_next();
         end
         n_vec++;
         if (cnt != ((k == 0) ? 2 : 1)) begin
            n_err++;
            $display("FAIL skz_pc_inc_count az=%0d got=%0d exp=%0d", acc_zero, cnt, (k == 0) ? 2 : 1);
         end
      end
      acc_zero = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] e;
      logic [OP_W-1:0] op;
      for (int i = 0; i < 10; i++) begin
         op = OP_W'($urandom_range(1, 7));
         acc_zero = 1'($urandom_range(0, 1));
         expect_instr(op, $urandom_range(1, 3), $urandom_range(1, 3), acc_zero, 1'b0, 1'b0);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
               n_err++;
               $display("FAIL back_to_back i=%0d op=%0d got=%h exp=%h", i, op, obs, e);
            end
            drive_next();
         end
      end
      acc_zero = 1'b0;
   endtask

   task automatic test_step();
      logic [VW-1:0] e;
      int cyc;
      step_en = 1'b1;
      for (int j = 0; j < 10; j++)
         push(vec(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 4'd2, 1'b0);
      // one release; step_go high outside IDLE must not release another
      expect_instr(4'd3, 2, 2, 1'b0, 1'b1, 1'b1);
      for (int j = 0; j < 3; j++)
         push(vec(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 4'd2, 1'b0);
      // step_go held high: one instruction per IDLE visit
      expect_instr(4'd7, 1, 1, 1'b0, 1'b1, 1'b1);
      expect_instr(4'd6, 1, 1, 1'b0, 1'b1, 1'b1);
      push(vec(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 4'd2, 1'b0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL step_mode cyc=%0d got=%h exp=%h", cyc, obs, e);
         end
         cyc++;
         drive_next();
      end
   endtask

   task automatic test_jmp_hlt();
      logic [VW-1:0] e;
      int cyc;
      step_en = 1'b0;
      expect_instr(4'd7, 1, 1, 1'b0, 1'b0, 1'b0);
      expect_instr(4'd0, 2, 1, 1'b0, 1'b0, 1'b0);
      push_halt(20);
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL jmp_hlt cyc=%0d got=%h exp=%h", cyc, obs, e);
         end
         cyc++;
         drive_next();
      end
   endtask

   task automatic test_illegal();
      logic [VW-1:0] e;
      int cyc;
      rst_n = 1'b0;
      step_go = 1'b0;
      mem_ack = 1'b0;
      exp_ill = 1'b0;
      #1;
      e = vec(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_clears_halt got=%h exp=%h", obs, e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      expect_instr(4'b1010, 1, 1, 1'b0, 1'b0, 1'b0);
      push_halt(6);
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL illegal_opcode cyc=%0d got=%h exp=%h", cyc, obs, e);
         end
         cyc++;
         drive_next();
      end
      rst_n = 1'b0;
      exp_ill = 1'b0;
      #1;
      e = vec(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_clears_illegal got=%h exp=%h", obs, e);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_alu_zero_wait();
      test_sto_wait();
      test_skz();
      test_back_to_back();
      test_step();
      test_jmp_hlt();
      test_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle control FSM for the accumulator RISC CPU; successor to the single-cycle opcode decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
- Adds a req/ack memory handshake, a zero-flag-driven skip, a sticky halt, and a single-step debug mode.
- Sits between the instruction register, PC, ALU/accumulator and the memory port.

Parameters:
- OP_W, 3, opcode width. Opcode decode uses bits [2:0]; any upper bits must be 0, otherwise the opcode is illegal.
- ALUOP_W, 2, width of the alu_op output.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OP_W  instruction-register opcode field, valid from DECODE onward
- acc_zero  in  1  accumulator == 0
- mem_ack  in  1  memory completion, sampled on the clk edge
- step_en  in  1  single-step mode enable
- step_go  in  1  single-cycle pulse that releases one instruction in step mode
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write (STO data phase)
- ir_load  out  1  load instruction register
- pc_inc  out  1  PC += 1
- pc_load  out  1  PC <= operand address (JMP)
- acc_load  out  1  accumulator write enable
- alu_to_acc  out  1  accumulator source: 1 = ALU, 0 = memory data
- alu_op  out  ALUOP_W  ALU function: 01 ADD, 10 AND, 11 XOR, 00 pass
- halted  out  1  controller is in HALT
- illegal  out  1  sticky flag: illegal opcode seen

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. State and all outputs are registered.
- Reset (async, rst_n=0): state=IDLE; every output=0. Reset mid-handshake drops mem_req immediately, with no wait for ack.
- IDLE:
  - step_en=0: go to FETCH next cycle.
  - step_en=1: wait for step_go=1, then go to FETCH.
- FETCH:
  - mem_req=1, mem_we=0.
  - Stay while mem_ack=0.
  - On an edge with mem_ack=1: next cycle pulses ir_load=1 and pc_inc=1 for exactly one cycle, and state=DECODE.
- DECODE: one cycle; the opcode is latched internally. Next state by opcode:
  - 000 HLT: HALT.
  - 001 SKZ: if acc_zero=1, one pc_inc pulse in EXEC; else no pc_inc.
  - 010/011/100 (ADD/AND/XOR): MEM (operand read).
  - 101 LDA: MEM.
  - 110 STO: MEM with mem_we=1.
  - 111 JMP: EXEC with pc_load=1 for one cycle.
  - Illegal (upper bits ≠ 0): set illegal=1, go to HALT.
- MEM:
  - mem_req=1; mem_we=1 only for STO.
  - Hold until an edge with mem_ack=1.
  - Then go to WB for ALU ops and LDA; go to IDLE for STO.
- WB: one cycle.
  - ALU ops: acc_load=1, alu_to_acc=1, alu_op per opcode (010→01, 011→10, 100→11).
  - LDA: acc_load=1, alu_to_acc=0, alu_op=00.
  - Then go to IDLE.
- EXEC (SKZ/JMP): one cycle, then IDLE.
- IDLE between instructions costs 1 cycle.
  - Latency: ALU/LDA = 1+F+1+M+1 cycles (F, M = wait cycles incl. ack ≥1); STO = 1+F+1+M; JMP/SKZ = 1+F+1+1.
- HALT: halted=1; all other strobes 0. Exits only on reset; illegal stays set until reset.
- Single-step:
  - step_go is ignored outside IDLE.
  - step_go held high releases one instruction per IDLE visit.
  - Clearing step_en mid-instruction has no effect until the next IDLE.
- mem_ack sampled while mem_req=0 is ignored.
- ack in the same cycle mem_req rises counts: a zero-wait memory gives F=M=1.
- Outputs alu_op, acc_load, mem_we, pc_load are never asserted outside their listed states.

Test Plan:
- Reset: rst_n=0 mid-MEM with mem_req=1 → mem_req=0 same cycle (async), all outputs 0, state IDLE; release → FETCH after 1 cycle.
- ADD, zero-wait memory: opcode=010, mem_ack tied 1 → ir_load/pc_inc pulse once, WB cycle shows acc_load=1, alu_to_acc=1, alu_op=01, total 5 cycles IDLE-to-IDLE.
- STO with 3-cycle ack delay in MEM: opcode=110 → mem_req=1 and mem_we=1 held 3 cycles, acc_load never 1, return to IDLE.
- SKZ: acc_zero=1 → exactly two pc_inc pulses (fetch + EXEC). acc_zero=0 → exactly one.
- JMP then HLT: opcode=111 → one pc_load pulse. Next opcode=000 → halted=1 stays high for 20 cycles regardless of mem_ack/step_go.
- Step mode / illegal: step_en=1, no step_go for 10 cycles → stays IDLE, mem_req=0; one step_go → exactly one instruction. With OP_W=4 and opcode=4'b1010 → illegal=1, halted=1.
